dram_array_responder: RTL
=========================

// Module: dram_array_responder
// PURPOSE
//  Responder end of the multiplexed-address DRAM interface that the RAS/CAS timing
//  generator drives. It models a bank of 4116-style 16K x N dynamic RAMs for the
//  bitmap/video memory in simulation and in the FPGA build.
//  All DRAM strobes are oversampled on CLK10: row/column latch, read, early/late
//  write, RAS-only refresh, refresh-window check and protocol-violation flagging.
// PARAMETERS
//  DATA_W          8      data bits per address (one 4116 per bit)
//  ADDR_W          7      multiplexed address width; array depth 2**(2*ADDR_W)
//  REFRESH_WINDOW  20000  CLK10 cycles each row must be refreshed in (2 ms @ 10 MHz)
//  TRP_MIN         1      minimum CLK10 cycles RASn held high between RAS cycles
// PORTS
//  CLK10        in   1       system clock; every register samples on rising edge
//  RESETn       in   1       synchronous active-low reset
//  RASn         in   1       row address strobe, active low
//  CASn         in   1       column address strobe, active low
//  WEn          in   1       write enable, active low
//  MA           in   ADDR_W  multiplexed address (row at RAS fall, column at CAS fall)
//  DIN          in   DATA_W  write data
//  DOUT         out  DATA_W  read data
//  DOUT_OE      out  1       DOUT valid / bus driven
//  REFRESH_ERR  out  1       sticky: a row missed a refresh window
//  PROTO_ERR    out  1       sticky: strobe-ordering or precharge violation
// BEHAVIOUR
//  - Edge detect: ras_q/cas_q/we_q register the strobes. Fall = q==1 && pin==0;
//    rise = q==0 && pin==1. Pins are used as-is with no extra synchronizer stages.
//  - Reset: ras_q=cas_q=we_q=1, state=IDLE, row=col=0, DOUT=0, DOUT_OE=0,
//    REFRESH_ERR=0, PROTO_ERR=0, refreshed[]=0, window counter=0.
//    Array contents are preserved. Reset mid-cycle aborts it with no write.
//    A strobe already low when reset is released counts as a fall on the first cycle.
//  - FSM states: IDLE, RAS_ACT, CAS_RD, CAS_WR, CAS_HOLD.
//  - IDLE:
//      RAS fall -> RAS_ACT; row<=MA; refreshed[MA]<=1.
//      If fewer than TRP_MIN cycles elapsed since the last RAS rise, PROTO_ERR<=1.
//        The access still proceeds.
//      CAS fall while RASn high -> PROTO_ERR<=1; state stays IDLE.
//  - RAS_ACT:
//      RAS rise with CAS never low -> IDLE. This is a RAS-only refresh.
//      CAS fall with WEn=0 -> early write: mem[{row,MA}]<=DIN; CAS_WR; DOUT_OE stays 0.
//      CAS fall with WEn=1 -> col<=MA; CAS_RD. Next cycle DOUT<=mem[{row,col}] and
//        DOUT_OE<=1. Read latency is 1 cycle after the CAS fall is sampled.
//  - CAS_RD:
//      DOUT held stable.
//      WEn fall -> late / read-modify-write: mem[{row,col}]<=DIN; DOUT_OE<=0; CAS_WR.
//      Only one write per CAS cycle.
//      CAS rise -> DOUT_OE<=0; RAS_ACT. Page-mode reads are allowed.
//      RAS rise while CASn low -> CAS_HOLD.
//  - CAS_WR:
//      Further WEn activity is ignored.
//      CAS rise -> RAS_ACT.
//      RAS rise while CASn low -> CAS_HOLD.
//  - CAS_HOLD (hidden refresh):
//      DOUT and DOUT_OE unchanged.
//      RAS fall -> refreshed[MA]<=1; state unchanged.
//      RAS rise -> no action.
//      CAS rise -> DOUT_OE<=0; IDLE.
//  - Same-cycle RAS fall and CAS fall in IDLE: the row latches and PROTO_ERR<=1.
//    The CAS fall is ignored; the next CAS fall starts the column cycle.
//  - Refresh check: the window counter counts 0..REFRESH_WINDOW-1 and wraps.
//    On wrap, REFRESH_ERR<=1 if any refreshed[] bit is 0, then all bits clear.
//    A refresh in the wrap cycle counts toward the new window.
//  - Error flags clear only on reset.
//  - Address composition: {row,col} gives 2*ADDR_W bits. No wrap or out-of-range case.
// TESTING
//  1 Write then read: RAS fall MA=7'h12, CAS fall MA=7'h34 WEn=0 DIN=8'hA5;
//    later read of the same address -> DOUT=8'hA5, DOUT_OE=1 one cycle after CAS fall.
//  2 Page mode: one RAS, CAS pulses at col 0,1,2 after prior writes 11/22/33 ->
//    DOUT=11,22,33; DOUT_OE low between CAS pulses.
//  3 Read-modify-write: read 8'hA5, then drop WEn with DIN=8'h5A while CASn low ->
//    DOUT_OE drops; a re-read returns 8'h5A.
//  4 Refresh: REFRESH_WINDOW=256; RAS-only refresh of rows 0..127 every window ->
//    REFRESH_ERR=0. Skip row 77 once -> REFRESH_ERR=1 at the next wrap, sticky.
//  5 Protocol: CAS fall with RASn high -> PROTO_ERR=1, no write.
//    TRP_MIN=3 and RAS high for 1 cycle -> PROTO_ERR=1.
//  6 Reset mid-CAS_RD -> next cycle DOUT_OE=0, DOUT=0, flags 0;
//    previously written data still readable.

Source files
------------

// File: rtl/dram_array_responder.sv
// Responder model of a 4116-style multiplexed-address DRAM bank. Strobes are oversampled on
// CLK10 to decode row/column latch, read, early/late write, RAS-only and hidden refresh.
module dram_array_responder #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned REFRESH_WINDOW = 20000,
  parameter int unsigned TRP_MIN        = 1
) (
  input  logic              CLK10,
  input  logic              RESETn,
  input  logic              RASn,
  input  logic              CASn,
  input  logic              WEn,
  input  logic [ADDR_W-1:0] MA,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_OE,
  output logic              REFRESH_ERR,
  output logic              PROTO_ERR
);

  localparam int unsigned Rows  = 2 ** ADDR_W;
  localparam int unsigned Depth = 2 ** (2 * ADDR_W);
  localparam int unsigned WinW  = (REFRESH_WINDOW > 1) ? $clog2(REFRESH_WINDOW) : 1;
  localparam int unsigned PreW  = $clog2(TRP_MIN + 1);

  localparam logic [WinW-1:0] WinLast = WinW'(REFRESH_WINDOW - 1);
  localparam logic [PreW-1:0] PreSat  = PreW'(TRP_MIN);

  typedef enum logic [2:0] {
    StIdle,
    StRasAct,
    StCasRd,
    StCasWr,
    StCasHold
  } state_e;

  state_e                  state_q, state_d;
  logic                    ras_q, cas_q, we_q;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]       col_q, col_d;
  logic                    oe_q, oe_d;
  logic                    ref_err_q, ref_err_d;
  logic                    proto_err_q, proto_err_d;
  logic [Rows-1:0]         refreshed_q, refreshed_d;
  logic [WinW-1:0]         win_q, win_d;
  logic [PreW-1:0]         pre_cnt_q, pre_cnt_d;
  logic [DATA_W-1:0]       dout_q;
  logic [DATA_W-1:0]       mem_q [Depth];

  logic                    ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
  logic                    ref_evt, wr_en, rd_en;
  logic [2*ADDR_W-1:0]     wr_addr;

  assign ras_fall = ras_q & ~RASn;
  assign ras_rise = ~ras_q & RASn;
  assign cas_fall = cas_q & ~CASn;
  assign cas_rise = ~cas_q & CASn;
  assign we_fall  = we_q & ~WEn;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    oe_d        = oe_q;
    proto_err_d = proto_err_q;
    ref_evt     = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_addr     = {row_q, col_q};

    unique case (state_q)
      StIdle: begin
        if (ras_fall) begin
          state_d = StRasAct;
          row_d   = MA;
          ref_evt = 1'b1;
          // A simultaneous CAS fall is flagged and dropped; the next CAS fall starts the column.
          if ((pre_cnt_q < PreSat) || cas_fall) proto_err_d = 1'b1;
        end else if (cas_fall && RASn) begin
          proto_err_d = 1'b1;
        end
      end
      StRasAct: begin
        if (ras_rise) begin
          state_d = StIdle;
        end else if (cas_fall) begin
          col_d = MA;
          if (!WEn) begin
            wr_en   = 1'b1;
            wr_addr = {row_q, MA};
            state_d = StCasWr;
          end else begin
            state_d = StCasRd;
          end
        end
      end
      StCasRd: begin
        if (cas_rise) begin
          oe_d    = 1'b0;
          state_d = ras_rise ? StIdle : StRasAct;
        end else if (we_fall) begin
          wr_en   = 1'b1;
          oe_d    = 1'b0;
          state_d = ras_rise ? StCasHold : StCasWr;
        end else begin
          // Reloading every cycle keeps DOUT stable: the addressed word cannot change here.
          rd_en = 1'b1;
          oe_d  = 1'b1;
          if (ras_rise) state_d = StCasHold;
        end
      end
      StCasWr: begin
        if (cas_rise) begin
          state_d = ras_rise ? StIdle : StRasAct;
        end else if (ras_rise) begin
          state_d = StCasHold;
        end
      end
      StCasHold: begin
        if (ras_fall) ref_evt = 1'b1;
        if (cas_rise) begin
          oe_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh window bookkeeping and precharge timer.
  always_comb begin
    win_d       = win_q + 1'b1;
    refreshed_d = refreshed_q;
    ref_err_d   = ref_err_q;
    pre_cnt_d   = pre_cnt_q;

    if (win_q == WinLast) begin
      win_d       = '0;
      refreshed_d = '0;
      if (!(&refreshed_q)) ref_err_d = 1'b1;
    end
    if (ref_evt) refreshed_d[MA] = 1'b1;

    if (ras_rise) begin
      pre_cnt_d = PreW'(1);
    end else if (RASn && (pre_cnt_q < PreSat)) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK10) begin
    if (!RESETn) begin
      ras_q       <= 1'b1;
      cas_q       <= 1'b1;
      we_q        <= 1'b1;
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      oe_q        <= 1'b0;
      ref_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      refreshed_q <= '0;
      win_q       <= '0;
      pre_cnt_q   <= PreSat;
    end else begin
      ras_q       <= RASn;
      cas_q       <= CASn;
      we_q        <= WEn;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      oe_q        <= oe_d;
      ref_err_q   <= ref_err_d;
      proto_err_q <= proto_err_d;
      refreshed_q <= refreshed_d;
      win_q       <= win_d;
      pre_cnt_q   <= pre_cnt_d;
    end
  end

  always_ff @(posedge CLK10) begin
    if (!RESETn) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem_q[{row_q, col_q}];
    end
  end

  // Array contents survive reset; a write decoded in a reset cycle is discarded.
  always_ff @(posedge CLK10) begin
    if (RESETn && wr_en) mem_q[wr_addr] <= DIN;
  end

  assign DOUT        = dout_q;
  assign DOUT_OE     = oe_q;
  assign REFRESH_ERR = ref_err_q;
  assign PROTO_ERR   = proto_err_q;

endmodule
